// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message sequencer.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SEND,
        ST_WAIT,
        ST_COLLECT,
        ST_DONE
    } state_t;

    localparam int         BLOCK_BYTES    = 64;
    localparam int         LEN_OFFSET     = 56;
    localparam logic [7:0] PAD_BYTE       = 8'h80;
    localparam int         DIGEST_NIBBLES = 64;

endpackage

// File: rtl/sha256_pad_mux.sv
// Selects the byte presented to the hash core at block index idx:
// buffered message byte, the 0x80 terminator, the bit-length trailer, or zero.
module sha256_pad_mux #(
    parameter int LEN_W = 32
) (
    input  logic [5:0]       idx,
    input  logic [6:0]       fill_cnt,
    input  logic             msg_done,
    input  logic             pad80_sent,
    input  logic             final_block,
    input  logic [LEN_W-1:0] msg_len,
    input  logic [7:0]       buf_byte,
    output logic [7:0]       byte_out,
    output logic             pad80_now
);
    import sha256_pkg::*;

    logic [63:0] bit_len;
    logic [63:0] len_shift;

    always_comb begin
        bit_len   = {{(61-LEN_W){1'b0}}, msg_len, 3'b000};
        // Index 56..63 maps to big-endian byte 0..7 of the length word.
        len_shift = bit_len << {idx[2:0], 3'b000};
        pad80_now = ({1'b0, idx} == fill_cnt) && msg_done && !pad80_sent;
        byte_out  = 8'h00;
        if ({1'b0, idx} < fill_cnt) begin
            byte_out = buf_byte;
        end else if (pad80_now) begin
            byte_out = PAD_BYTE;
        end else if (final_block && (idx >= 6'(LEN_OFFSET))) begin
            byte_out = len_shift[63:56];
        end
    end

endmodule

// File: rtl/sha256_msg_sequencer.sv
// Buffers a byte message into 64-byte blocks, streams padded blocks to the
// SHA-256 core, and gathers the core's nibble digest into a 256-bit result.
module sha256_msg_sequencer #(
    parameter int LEN_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         in_ready,
    output logic [7:0]   core_data,
    output logic         core_write_enable,
    output logic         core_first_block,
    output logic         core_last_block,
    input  logic         core_busy,
    input  logic [3:0]   core_digest,
    input  logic         core_output_valid,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic         busy
);
    import sha256_pkg::*;

    state_t           state, next_state;
    logic [6:0]       fill_cnt;
    logic [LEN_W-1:0] msg_len;
    logic             msg_done;
    logic             pad80_sent;
    logic             later_block;
    logic             busy_seen;
    logic [5:0]       byte_idx;
    logic [5:0]       nib_cnt;
    logic [7:0]       blk_buf [BLOCK_BYTES];

    logic             accept;
    logic             store;
    logic             final_block;
    logic             busy_fall;
    logic [7:0]       pad_byte;
    logic             pad80_now;

    assign accept      = in_valid && in_ready;
    assign store       = accept && !in_empty;
    assign final_block = msg_done && (fill_cnt < 7'(LEN_OFFSET));
    assign busy_fall   = busy_seen && !core_busy;
    assign core_data   = core_write_enable ? pad_byte : 8'h00;

    sha256_pad_mux #(.LEN_W(LEN_W)) u_pad_mux (
        .idx        (byte_idx),
        .fill_cnt   (fill_cnt),
        .msg_done   (msg_done),
        .pad80_sent (pad80_sent),
        .final_block(final_block),
        .msg_len    (msg_len),
        .buf_byte   (blk_buf[byte_idx]),
        .byte_out   (pad_byte),
        .pad80_now  (pad80_now)
    );

    always_comb begin
        next_state        = state;
        in_ready          = 1'b0;
        core_write_enable = 1'b0;
        core_first_block  = 1'b0;
        core_last_block   = 1'b0;
        digest_valid      = 1'b0;
        busy              = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (accept) next_state = in_last ? ST_SEND : ST_FILL;
            end
            ST_FILL: begin
                in_ready = (fill_cnt != 7'(BLOCK_BYTES));
                if (accept && (in_last || (store && fill_cnt == 7'(BLOCK_BYTES-1))))
                    next_state = ST_SEND;
            end
            ST_SEND: begin
                core_write_enable = 1'b1;
                core_first_block  = (byte_idx == 6'd0) && !later_block;
                core_last_block   = (byte_idx == 6'd0) && final_block;
                if (byte_idx == 6'(BLOCK_BYTES-1)) next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (busy_fall) begin
                    if (final_block)   next_state = ST_COLLECT;
                    else if (msg_done) next_state = ST_SEND;
                    else               next_state = ST_FILL;
                end
            end
            ST_COLLECT: begin
                if (core_output_valid && nib_cnt == 6'(DIGEST_NIBBLES-1)) next_state = ST_DONE;
            end
            ST_DONE: begin
                digest_valid = 1'b1;
                if (digest_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            fill_cnt    <= '0;
            msg_len     <= '0;
            msg_done    <= 1'b0;
            pad80_sent  <= 1'b0;
            later_block <= 1'b0;
            busy_seen   <= 1'b0;
            byte_idx    <= '0;
            nib_cnt     <= '0;
            digest      <= '0;
        end else begin
            state <= next_state;
            if (store) begin
                fill_cnt <= fill_cnt + 7'd1;
                msg_len  <= msg_len + 1'b1;
            end
            if (accept && in_last) msg_done <= 1'b1;
            // byte_idx wraps to 0 at the end of each block
            if (state == ST_SEND) begin
                byte_idx <= byte_idx + 6'd1;
                if (pad80_now) pad80_sent <= 1'b1;
                if (byte_idx == 6'(BLOCK_BYTES-1)) later_block <= 1'b1;
            end
            if (state == ST_WAIT) begin
                if (core_busy) busy_seen <= 1'b1;
                if (busy_fall) begin
                    busy_seen <= 1'b0;
                    if (!final_block) fill_cnt <= '0;
                end
            end
            if (state == ST_COLLECT && core_output_valid) begin
                digest  <= {digest[251:0], core_digest};
                nib_cnt <= nib_cnt + 6'd1;
            end
            if (state == ST_DONE && digest_ready) begin
                fill_cnt    <= '0;
                msg_len     <= '0;
                msg_done    <= 1'b0;
                pad80_sent  <= 1'b0;
                later_block <= 1'b0;
            end
        end
    end

    // Message bytes are pure data: no reset needed.
    always_ff @(posedge clk) begin
        if (store) blk_buf[fill_cnt[5:0]] <= in_data;
    end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Bench for sha256_msg_sequencer with a behavioural SHA-256 core model and a block/digest scoreboard.
`timescale 1ns/1ps
module tb_sha256_msg_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid, in_last, in_empty, in_ready;
    logic [7:0]   core_data;
    logic         core_write_enable, core_first_block, core_last_block;
    logic         core_busy;
    logic [3:0]   core_digest;
    logic         core_output_valid;
    logic [255:0] digest;
    logic         digest_valid, digest_ready, busy;

    always #5 clk = ~clk;

    sha256_msg_sequencer #(.LEN_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_empty(in_empty),
        .in_ready(in_ready),
        .core_data(core_data), .core_write_enable(core_write_enable),
        .core_first_block(core_first_block), .core_last_block(core_last_block),
        .core_busy(core_busy), .core_digest(core_digest), .core_output_valid(core_output_valid),
        .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready), .busy(busy)
    );

    typedef struct { logic [511:0] data; logic first; logic last; } blk_t;

    localparam logic [255:0] H0      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_NIL = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    blk_t         exp_blk_q [$];
    logic [255:0] exp_dig_q [$];
    logic [511:0] blk_log   [$];
    logic [7:0]   msg       [$];

    int  n_checks = 0, n_pass = 0;
    int  blocks_sent = 0, rdy_viol = 0, flag_viol = 0, gap_viol = 0;
    int  mon_cnt = 0, busy_t = 0, nib_left = 0;
    time last_nib_t = 0;
    logic [511:0] mon_blk;
    logic         blk_first, blk_last, cm_last;
    logic [255:0] cm_h;
    blk_t         eb;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // Core model and block monitor: captures blocks, compresses, signals busy, streams nibbles.
    initial begin
        core_busy = 1'b0; core_output_valid = 1'b0; core_digest = 4'h0;
        cm_h = H0; cm_last = 1'b0; blk_first = 1'b0; blk_last = 1'b0; mon_blk = '0;
        forever begin
            @(negedge clk);
            core_output_valid = 1'b0;
            if (reset) begin
                mon_cnt = 0; busy_t = 0; nib_left = 0; core_busy = 1'b0;
                continue;
            end
            if ((core_write_enable || core_busy) && in_ready) rdy_viol++;
            if (core_write_enable) begin
                if (mon_cnt == 0) begin
                    blk_first = core_first_block; blk_last = core_last_block;
                end else if (core_first_block || core_last_block) begin
                    flag_viol++;
                end
                mon_blk[511-8*mon_cnt -: 8] = core_data;
                mon_cnt++;
                if (mon_cnt == 64) begin
                    mon_cnt = 0;
                    blocks_sent++;
                    blk_log.push_back(mon_blk);
                    n_checks++;
                    if (exp_blk_q.size() == 0) begin
                        $display("FAIL block_unexpected got %h", mon_blk);
                    end else begin
                        eb = exp_blk_q.pop_front();
                        if (mon_blk !== eb.data || blk_first !== eb.first || blk_last !== eb.last)
                            $display("FAIL block%0d got %h f%b l%b exp %h f%b l%b", blocks_sent,
                                     mon_blk, blk_first, blk_last, eb.data, eb.first, eb.last);
                        else n_pass++;
                    end
                    if (blk_first) cm_h = H0;
                    cm_h      = sha_compress(cm_h, mon_blk);
                    cm_last   = blk_last;
                    core_busy = 1'b1;
                    busy_t    = 2 + int'($urandom_range(0, 3));
                end
            end else begin
                if (mon_cnt != 0) begin gap_viol++; mon_cnt = 0; end
                if (busy_t > 0) begin
                    busy_t--;
                    if (busy_t == 0) begin
                        core_busy = 1'b0;
                        if (cm_last) nib_left = 64;
                    end
                end else if (nib_left > 0 && $urandom_range(0, 3) != 0) begin
                    core_output_valid = 1'b1;
                    core_digest       = cm_h[4*nib_left-1 -: 4];
                    nib_left--;
                    if (nib_left == 0) last_nib_t = $time;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Pushes reference blocks/digest for msg, then drives the beats.
    task automatic send_msg(input bit gaps, input bit empty_tail);
        logic [7:0]   p [$];
        logic [63:0]  bl;
        logic [255:0] h;
        logic [511:0] blk;
        int nb, nbeats, t;
        bit done, last_b, empty_b;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
        nb = p.size() / 64;
        h  = H0;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
            exp_blk_q.push_back('{blk, (b == 0), (b == nb - 1)});
            h = sha_compress(h, blk);
        end
        exp_dig_q.push_back(h);
        nbeats = msg.size() + ((empty_tail || msg.size() == 0) ? 1 : 0);
        for (int i = 0; i < nbeats; i++) begin
            last_b  = (i == nbeats - 1);
            empty_b = (i >= msg.size());
            done = 1'b0; t = 0;
            while (!done && t < 2000) begin
                in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                if (empty_b) in_data = 8'h00; else in_data = msg[i];
                in_last  = last_b;
                in_empty = empty_b;
                done     = in_valid && in_ready;
                step();
                t++;
            end
            if (!done) begin
                n_checks++;
                $display("FAIL beat_timeout beat %0d got in_ready=%b exp 1", i, in_ready);
                break;
            end
        end
        in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
    endtask

    task automatic wait_digest(input int hold, output logic [255:0] got);
        int t;
        bit changed;
        logic [255:0] e;
        t = 0; changed = 1'b0; got = '0;
        while (digest_valid !== 1'b1 && t < 3000) begin step(); t++; end
        n_checks++;
        if (digest_valid !== 1'b1) begin
            $display("FAIL digest_timeout got valid=%b exp 1", digest_valid);
            return;
        end
        n_pass++;
        n_checks++;
        if ($time != last_nib_t + 11) $display("FAIL digest_latency got %0t exp %0t", $time, last_nib_t + 11);
        else n_pass++;
        got = digest;
        e = (exp_dig_q.size() > 0) ? exp_dig_q.pop_front() : 'x;
        n_checks++;
        if (got !== e) $display("FAIL digest_model got %h exp %h", got, e);
        else n_pass++;
        for (int i = 0; i < hold; i++) begin
            step();
            if (digest !== got || digest_valid !== 1'b1) changed = 1'b1;
        end
        if (hold > 0) begin
            n_checks++;
            if (changed || digest !== got) $display("FAIL hold_stable got changed=%b exp 0", changed);
            else n_pass++;
            n_checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL hold_ctrl got busy=%b in_ready=%b exp busy=1 in_ready=0", busy, in_ready);
            else n_pass++;
        end
        digest_ready = 1'b1;
        step();
        digest_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || digest_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL release got busy=%b dv=%b rdy=%b exp 0 0 1", busy, digest_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_checks++;
        if (core_write_enable !== 1'b0 || core_first_block !== 1'b0 || core_last_block !== 1'b0)
            $display("FAIL reset_core got we=%b f=%b l=%b exp 0", core_write_enable, core_first_block, core_last_block);
        else n_pass++;
        n_checks++;
        if (digest_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_status got dv=%b busy=%b exp 0 0", digest_valid, busy);
        else n_pass++;
        n_checks++;
        if (digest !== 256'h0) $display("FAIL reset_digest got %h exp 0", digest);
        else n_pass++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_abc();
        logic [255:0] d;
        logic [511:0] b0;
        int nb0;
        msg = '{8'h61, 8'h62, 8'h63};
        blk_log.delete();
        nb0 = blocks_sent;
        send_msg(1'b0, 1'b0);
        wait_digest(0, d);
        b0 = (blk_log.size() > 0) ? blk_log[0] : 'x;
        n_checks++;
        if (blocks_sent - nb0 != 1) $display("FAIL abc_blocks got %0d exp 1", blocks_sent - nb0);
        else n_pass++;
        n_checks++;
        if (b0[511:480] !== 32'h61626380 || b0[63:0] !== 64'h18)
            $display("FAIL abc_bytes got %h exp 61626380..0018", b0);
        else n_pass++;
        n_checks++;
        if (d !== DIG_ABC) $display("FAIL abc_digest got %h exp %h", d, DIG_ABC);
        else n_pass++;
    endtask

    task automatic test_empty();
        logic [255:0] d;
        logic [511:0] b0;
        logic [511:0] want;
        int nb0;
        msg.delete();
        blk_log.delete();
        nb0  = blocks_sent;
        want = {8'h80, 504'h0};
        send_msg(1'b0, 1'b0);
        wait_digest(0, d);
        b0 = (blk_log.size() > 0) ? blk_log[0] : 'x;
        n_checks++;
        if (blocks_sent - nb0 != 1 || b0 !== want) $display("FAIL empty_block got n=%0d %h exp 1 %h", blocks_sent - nb0, b0, want);
        else n_pass++;
        n_checks++;
        if (d !== DIG_NIL) $display("FAIL empty_digest got %h exp %h", d, DIG_NIL);
        else n_pass++;
    endtask

    task automatic test_boundaries();
        int          lens   [3] = '{55, 56, 64};
        int          exp_nb [3] = '{1, 2, 2};
        int          pad_blk[3] = '{0, 0, 1};
        int          pad_pos[3] = '{55, 56, 0};
        logic [15:0] lenv   [3] = '{16'h01B8, 16'h01C0, 16'h0200};
        logic [255:0] d;
        logic [511:0] pb, lb;
        int nb0;
        for (int c = 0; c < 3; c++) begin
            msg.delete();
            for (int i = 0; i < lens[c]; i++) msg.push_back(8'h61);
            blk_log.delete();
            nb0 = blocks_sent;
            send_msg(1'b0, 1'b0);
            wait_digest(0, d);
            n_checks++;
            if (blocks_sent - nb0 != exp_nb[c]) $display("FAIL bnd%0d_blocks got %0d exp %0d", lens[c], blocks_sent - nb0, exp_nb[c]);
            else n_pass++;
            pb = (blk_log.size() > pad_blk[c]) ? blk_log[pad_blk[c]] : 'x;
            lb = (blk_log.size() >= exp_nb[c]) ? blk_log[exp_nb[c]-1] : 'x;
            n_checks++;
            if (pb[511-8*pad_pos[c] -: 8] !== 8'h80) $display("FAIL bnd%0d_pad got %h exp 80", lens[c], pb[511-8*pad_pos[c] -: 8]);
            else n_pass++;
            n_checks++;
            if (lb[15:0] !== lenv[c]) $display("FAIL bnd%0d_len got %h exp %h", lens[c], lb[15:0], lenv[c]);
            else n_pass++;
        end
    endtask

    task automatic test_random_valid();
        logic [255:0] d;
        int nb0, rv0, gv0, fv0;
        msg.delete();
        for (int i = 0; i < 130; i++) msg.push_back(8'($urandom));
        nb0 = blocks_sent; rv0 = rdy_viol; gv0 = gap_viol; fv0 = flag_viol;
        send_msg(1'b1, 1'b1);
        wait_digest(0, d);
        n_checks++;
        if (blocks_sent - nb0 != 3) $display("FAIL rnd_blocks got %0d exp 3", blocks_sent - nb0);
        else n_pass++;
        n_checks++;
        if (rdy_viol != rv0) $display("FAIL rnd_in_ready got %0d exp 0 cycles ready during send/wait", rdy_viol - rv0);
        else n_pass++;
        n_checks++;
        if (gap_viol != gv0 || flag_viol != fv0)
            $display("FAIL rnd_contig got gaps=%0d flags=%0d exp 0 0", gap_viol - gv0, flag_viol - fv0);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        logic [255:0] d;
        msg.delete();
        for (int i = 0; i < 20; i++) msg.push_back(8'($urandom));
        send_msg(1'b0, 1'b0);
        wait_digest(20, d);
    endtask

    task automatic test_reset_mid();
        logic [255:0] d;
        int t;
        msg = '{8'h61, 8'h62, 8'h63};
        send_msg(1'b0, 1'b0);
        t = 0;
        while (!(core_write_enable === 1'b1 && mon_cnt == 31) && t < 300) begin step(); t++; end
        n_checks++;
        if (!(core_write_enable === 1'b1 && mon_cnt == 31)) $display("FAIL mid_reach got cnt=%0d exp 31", mon_cnt);
        else n_pass++;
        reset = 1'b1;
        step();
        n_checks++;
        if (core_write_enable !== 1'b0 || busy !== 1'b0 || digest_valid !== 1'b0)
            $display("FAIL mid_reset got we=%b busy=%b dv=%b exp 0 0 0", core_write_enable, busy, digest_valid);
        else n_pass++;
        step();
        reset = 1'b0;
        exp_blk_q.delete();
        exp_dig_q.delete();
        step();
        msg = '{8'h61, 8'h62, 8'h63};
        send_msg(1'b0, 1'b0);
        wait_digest(0, d);
        n_checks++;
        if (d !== DIG_ABC) $display("FAIL mid_abc_digest got %h exp %h", d, DIG_ABC);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_empty = 1'b0; digest_ready = 1'b0;
        test_reset();
        test_abc();
        test_empty();
        test_boundaries();
        test_random_valid();
        test_back_pressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sequencer.md
Name: sha256_msg_sequencer

Overview:
Front-end controller that turns an arbitrary-length byte message into padded 512-bit SHA-256 blocks and sequences the hash core through them. It owns the core's input protocol: byte streaming, first/last block flags, and waiting on core busy. After the final block it collects the core's 4-bit digest stream into a 256-bit result with a valid/ready handshake. It sits between the host byte interface and the SHA-256 top.

Parameters:
- LEN_W, 32, width of the message byte counter; maximum message length is 2^LEN_W-1 bytes.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- in_data  in  8  message byte
- in_valid  in  1  in_data valid
- in_last  in  1  with in_valid: final beat of the message
- in_empty  in  1  with in_valid&in_last: beat carries no byte (zero-length message or trailing marker)
- in_ready  out  1  sequencer accepts a beat this cycle
- core_data  out  8  byte to hash core
- core_write_enable  out  1  core_data valid
- core_first_block  out  1  high on byte 0 of block 0 only
- core_last_block  out  1  high on byte 0 of the final block only
- core_busy  in  1  core compressing
- core_digest  in  4  digest nibble
- core_output_valid  in  1  core_digest valid
- digest  out  256  result, nibble 0 received in bits [255:252]
- digest_valid  out  1  digest holds a complete result
- digest_ready  in  1  consumer accepts digest
- busy  out  1  state != IDLE

Behaviour:
- Beat transfer happens when in_valid & in_ready. A beat with in_empty=1 stores no byte and does not advance the length.
- Reset values: all outputs 0, digest 0, counters 0, state IDLE.
- FSM states and transitions:
  - IDLE: in_ready=1. An accepted beat moves to FILL, and its byte is stored if not empty. If the accepted beat also has in_last=1, go to SEND instead.
  - FILL: stores accepted bytes into a 64x8 block buffer at fill_cnt and increments msg_len (LEN_W bits). in_ready=0 when fill_cnt==64. Buffer full, or in_last accepted, -> SEND.
  - SEND: exactly 64 consecutive cycles with core_write_enable=1 and byte index i=0..63. Byte source per index:
    - i<fill_cnt: buffer byte.
    - i==fill_cnt, message ended, and 0x80 not yet emitted: 0x80.
    - final block and i>=56: big-endian byte (i-56) of 64-bit bit length {msg_len,3'b000}, zero-extended.
    - otherwise 0x00.
    - The final block is the one where the message has ended and fill_cnt<=55 (0x80 emitted in this block, or already emitted in a prior block).
    - After i==63 -> WAIT.
  - WAIT: goes high-then-low on core_busy; rise must occur before the fall is honoured. On fall:
    - if final block -> COLLECT;
    - else if message ended -> SEND with fill_cnt=0 (pad-only block; 0x80 present only if not yet emitted);
    - else -> FILL with fill_cnt=0.
  - COLLECT: shifts core_digest into digest on each core_output_valid. After 64 nibbles -> DONE.
  - DONE: digest_valid=1 and digest held stable. On digest_ready -> IDLE, with counters and the 0x80 flag cleared.
- Length boundaries (L = message length in bytes, mod 64):
  - L<=55: 1 trailing block.
  - 56..63: 0x80 in the current block, length in an extra block.
  - L%64==0: extra block starting with 0x80.
- Latency: digest_valid rises exactly 1 cycle after the 64th core_output_valid.
- Reset mid-operation returns to IDLE in one cycle. core_write_enable drops immediately and any partial block is discarded.
- in_last while in_ready=0 is not accepted; the host must hold it.
- msg_len saturates silently are not required: lengths >2^LEN_W-1 are out of contract.

Decomposition:
- Package sha256_pkg holds the state enum, BLOCK_BYTES=64, LEN_OFFSET=56, PAD_BYTE=8'h80, DIGEST_NIBBLES=64.
- One sub-module, sha256_pad_mux: combinational byte select from (i, fill_cnt, msg_done, pad80_sent, final, msg_len). This is the piece that gets unit-tested exhaustively against a software model.

Test Plan:
- "abc" (3 beats, last on 'c'), core model in loop -> one SEND with core_first_block and core_last_block on the same cycle; bytes 61 62 63 80, zeros, ..00 18. digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Single beat in_valid&in_last&in_empty -> block 80 00..00 with all-zero length. digest=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- 55-byte 'a' message -> exactly 1 SEND. 56-byte and 64-byte 'a' messages -> exactly 2 SENDs. Check 0x80 position (byte 56 of block 0, and byte 0 of block 1, respectively), and length bytes 0x01C0 / 0x0200 at i=62..63 of block 1.
- in_valid toggling randomly during a 130-byte message -> in_ready=0 throughout SEND/WAIT. 3 blocks sent, each exactly 64 contiguous core_write_enable cycles; digest matches the software model.
- digest_ready held 0 for 20 cycles -> digest_valid and digest stable; busy=1, in_ready=0. Ready pulse -> IDLE the next cycle.
- reset asserted at SEND byte 30 -> next cycle: core_write_enable=0, state IDLE, digest_valid=0. A following "abc" produces the correct digest.
